// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait freeze, load-use bubble, ID branch flush.
// Optional HAZARD_PERF_EN builds stall-cycle and flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int TO_CYCLES = 255,
  parameter int TO_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs2_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             back_freeze_o,
  output logic             timeout_o,
  output logic [31:0]      stall_cycles_o,
  output logic [31:0]      flush_count_o,
  output logic             fsm_state_o
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] tcnt, tcnt_nxt;
  logic            timeout_set;
  logic            freeze;
  logic            load_use;

  assign fsm_state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      tcnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (timeout_set) timeout_o <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_nxt = MEM_WAIT;
          tcnt_nxt  = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_nxt = RUN;
        end else if (tcnt == TO_W'(TO_CYCLES - 1)) begin
          // Watchdog: give up on the access; the freeze still covers this cycle.
          state_nxt   = RUN;
          timeout_set = 1'b1;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    freeze = ((state == MEM_WAIT) && !mem_ready_i) ||
             ((state == RUN) && mem_req_i && !mem_ready_i);
    load_use = idex_memread_i && (idex_rd_i != '0) &&
               ((idex_rd_i == id_rs1_i) || (id_use_rs2_i && (idex_rd_i == id_rs2_i)));
  end

  // Priority: freeze masks load-use, load-use masks the branch flush.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    back_freeze_o = 1'b0;
    if (!rst_i) begin
      if (freeze) begin
        ifid_stall_o  = 1'b1;
        back_freeze_o = 1'b1;
      end else if (load_use) begin
        ifid_stall_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
        pc_write_o   = 1'b1;
      end else begin
        pc_write_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (!pc_write_o)  stall_cycles_o <= stall_cycles_o + 32'd1;
      if (ifid_flush_o) flush_count_o  <= flush_count_o + 32'd1;
    end
  end
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with a 4-cycle watchdog covers timeout.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0;
  logic       id_use_rs2 = 1'b0, idex_memread = 1'b0, branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  logic        a_pc, a_stall, a_flush, a_bubble, a_freeze, a_to, a_state;
  logic [31:0] a_scyc, a_fcnt;
  logic        b_pc, b_stall, b_flush, b_bubble, b_freeze, b_to, b_state;
  logic [31:0] b_scyc, b_fcnt;
  logic [5:0]  a_obs, b_obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // {pc_write, ifid_stall, ifid_flush, idex_bubble, back_freeze, timeout}
  assign a_obs = {a_pc, a_stall, a_flush, a_bubble, a_freeze, a_to};
  assign b_obs = {b_pc, b_stall, b_flush, b_bubble, b_freeze, b_to};

  pipeline_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs2_i(id_use_rs2), .idex_memread_i(idex_memread), .idex_rd_i(idex_rd),
    .branch_taken_i(branch_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .pc_write_o(a_pc), .ifid_stall_o(a_stall), .ifid_flush_o(a_flush),
    .idex_bubble_o(a_bubble), .back_freeze_o(a_freeze), .timeout_o(a_to),
    .stall_cycles_o(a_scyc), .flush_count_o(a_fcnt), .fsm_state_o(a_state)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .TO_CYCLES(4), .TO_W(8)) dut_to (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs2_i(id_use_rs2), .idex_memread_i(idex_memread), .idex_rd_i(idex_rd),
    .branch_taken_i(branch_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .pc_write_o(b_pc), .ifid_stall_o(b_stall), .ifid_flush_o(b_flush),
    .idex_bubble_o(b_bubble), .back_freeze_o(b_freeze), .timeout_o(b_to),
    .stall_cycles_o(b_scyc), .flush_count_o(b_fcnt), .fsm_state_o(b_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic apply(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic use2, input logic br,
                       input logic req, input logic rdy);
    @(negedge clk);
    idex_memread = mr; idex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs2 = use2; branch_taken = br; mem_req = req; mem_ready = rdy;
    #1;
  endtask

  task automatic quiet();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    quiet();
    check_eq("reset_outs", 32'(a_obs), 32'b000000);
    check_eq("reset_perf", a_scyc | a_fcnt, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check_eq("first_cycle", 32'(a_obs), 32'b100000);
    check_eq("first_state", 32'(a_state), 32'd0);

    // Load-use and branch
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("lu_rs1", 32'(a_obs), 32'b010100);
    quiet();
    check_eq("lu_release", 32'(a_obs), 32'b100000);
    apply(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("lu_rs2_unused", 32'(a_obs), 32'b100000);
    apply(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("lu_rs2_used", 32'(a_obs), 32'b010100);
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("lu_rd0", 32'(a_obs), 32'b100000);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("branch", 32'(a_obs), 32'b101000);
    apply(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("branch_vs_lu", 32'(a_obs), 32'b010100);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("branch2", 32'(a_obs), 32'b101000);
    quiet();
`ifdef HAZARD_PERF_EN
    check_eq("perf_stalls", a_scyc, 32'd3);
    check_eq("perf_flushes", a_fcnt, 32'd2);
`else
    check_eq("perf_stalls_off", a_scyc, 32'd0);
    check_eq("perf_flushes_off", a_fcnt, 32'd0);
`endif

    // Memory wait: six freeze cycles, ready pulse releases, branch masked until then
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_eq($sformatf("memwait_freeze%0d", i), 32'(a_obs), 32'b010010);
      if (i > 0) check_eq($sformatf("memwait_state%0d", i), 32'(a_state), 32'd1);
    end
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("memwait_release", 32'(a_obs), 32'b101000);
    quiet();
    check_eq("memwait_back_run", 32'(a_state), 32'd0);
    check_eq("memwait_quiet", 32'(a_obs), 32'b100000);

    // Hit and stray ready
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("hit_no_freeze", 32'(a_obs), 32'b100000);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("hit_state_run", 32'(a_state), 32'd0);
    check_eq("stray_ready", 32'(a_obs), 32'b100000);

    // Timeout on the 4-cycle instance, from a clean reset
    @(negedge clk); rst = 1'b1; #1;
    check_eq("to_reset", 32'(b_obs), 32'b000000);
    quiet();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq($sformatf("to_freeze%0d", i), 32'(b_obs), 32'b010010);
    end
    quiet();
    check_eq("to_flag_set", 32'(b_obs), 32'b100001);
    check_eq("to_state_run", 32'(b_state), 32'd0);
    quiet();
    check_eq("to_flag_sticky", 32'(b_to), 32'd1);

    // Reset in the middle of a wait
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("midwait_state", 32'(a_state), 32'd1);
    @(negedge clk); rst = 1'b1; #1;
    check_eq("midwait_rst_outs", 32'(a_obs), 32'b000000);
    check_eq("midwait_rst_state", 32'(a_state), 32'd0);
    check_eq("midwait_rst_to", 32'(b_obs), 32'b000000);
    quiet();
    rst = 1'b0;
    #1;
    check_eq("after_rst", 32'(a_obs), 32'b100000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
